// File: rtl/lab_readout_sched_if.sv
// Shared RAM read port plus the downstream word stream, seen from the scheduler side.
interface lab_readout_sched_if;
    logic [12:0] addr_o;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic [1:0]  lab_o;

    modport master (output addr_o, dat_o, valid_o, last_o, lab_o, input dat_i, ready_i);
    modport slave  (input addr_o, dat_o, valid_o, last_o, lab_o, output dat_i, ready_i);
endinterface

// File: rtl/lab_readout_sched.sv
// Four-LAB hold/digitize sequencer with round-robin readout of a shared RAM port (LAB_SCHED_DROP_CNT_EN adds a drop counter).
// Latency: hold 1 cycle after trigger, digitize HOLD_DLY later; one word per 3 cycles when ready_i stays high.
// Backpressure: dat_o/lab_o/last_o held while valid_o && !ready_i; READY LABs wait for the stream to free up.
module lab_readout_sched #(
    parameter int NWORDS      = 1536,
    parameter int HOLD_DLY    = 4,
    parameter int DIG_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  trig_i,
    output logic [3:0]  hold_o,
    output logic [3:0]  digitize_o,
    input  logic [3:0]  lab_done_i,
    output logic [3:0]  busy_o,
    output logic [3:0]  err_o,
`ifdef LAB_SCHED_DROP_CNT_EN
    output logic [15:0] drop_cnt_o,
    input  logic        drop_clr_i,
`endif
    lab_readout_sched_if.master rd
);

    localparam int HW = $clog2(HOLD_DLY + 1);
    localparam int TW = $clog2(DIG_TIMEOUT + 1);

    typedef enum logic [2:0] {L_IDLE, L_HOLD, L_DIGI, L_READY, L_STREAM} lab_st_t;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_OUT} str_st_t;

    lab_st_t         lab_st  [4];
    lab_st_t         lab_nxt [4];
    logic [HW-1:0]   hcnt    [4];
    logic [TW-1:0]   tcnt    [4];
    logic [3:0]      seen_low;
    logic [3:0]      timeout;
    logic [3:0]      grant_v;
    logic            grant_any;
    logic [1:0]      grant_idx;
    logic [1:0]      arb_idx;
    logic [1:0]      rr_ptr;
    logic            last_hs;
    str_st_t         s_st, s_nxt;
    logic [10:0]     word;
    logic [1:0]      cur_lab;

    // Per-LAB sequencers: state and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seen_low <= '0;
            for (int n = 0; n < 4; n++) begin
                lab_st[n] <= L_IDLE;
                hcnt[n]   <= '0;
                tcnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                lab_st[n] <= lab_nxt[n];
                if (lab_st[n] == L_IDLE)
                    hcnt[n] <= HW'(HOLD_DLY - 1);
                else if (lab_st[n] == L_HOLD && hcnt[n] != '0)
                    hcnt[n] <= hcnt[n] - HW'(1);
                if (lab_st[n] != L_DIGI) begin
                    tcnt[n]     <= '0;
                    seen_low[n] <= 1'b0;
                end else begin
                    tcnt[n] <= tcnt[n] + TW'(1);
                    // done may still be stale-high from the previous event; arm only once it reads low
                    if (!lab_done_i[n])
                        seen_low[n] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            lab_nxt[n] = lab_st[n];
            case (lab_st[n])
                L_IDLE:   if (trig_i[n]) lab_nxt[n] = L_HOLD;
                L_HOLD:   if (hcnt[n] == '0) lab_nxt[n] = L_DIGI;
                L_DIGI: begin
                    if (timeout[n])
                        lab_nxt[n] = L_IDLE;
                    else if (seen_low[n] && lab_done_i[n])
                        lab_nxt[n] = L_READY;
                end
                L_READY:  if (grant_v[n]) lab_nxt[n] = L_STREAM;
                L_STREAM: if (last_hs && cur_lab == 2'(n)) lab_nxt[n] = L_IDLE;
                default:  lab_nxt[n] = L_IDLE;
            endcase
        end
    end

    always_comb begin
        hold_o     = '0;
        busy_o     = '0;
        digitize_o = '0;
        timeout    = '0;
        for (int n = 0; n < 4; n++) begin
            hold_o[n]     = (lab_st[n] != L_IDLE);
            busy_o[n]     = (lab_st[n] != L_IDLE);
            digitize_o[n] = (lab_st[n] == L_DIGI) && (tcnt[n] == '0);
            timeout[n]    = (lab_st[n] == L_DIGI) && (tcnt[n] == TW'(DIG_TIMEOUT));
        end
        err_o = timeout;
    end

    // Round-robin pick of the first READY LAB at or after rr_ptr, only while the stream is idle.
    always_comb begin
        grant_v   = '0;
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        arb_idx   = rr_ptr;
        if (s_st == S_IDLE) begin
            for (int i = 0; i < 4; i++) begin
                arb_idx = rr_ptr + 2'(i);
                if (!grant_any && lab_st[arb_idx] == L_READY) begin
                    grant_any = 1'b1;
                    grant_idx = arb_idx;
                end
            end
        end
        if (grant_any)
            grant_v[grant_idx] = 1'b1;
    end

    assign last_hs = (s_st == S_OUT) && rd.valid_o && rd.ready_i && rd.last_o;

    always_comb begin
        s_nxt = s_st;
        case (s_st)
            S_IDLE:  if (grant_any) s_nxt = S_ADDR;
            S_ADDR:  s_nxt = S_WAIT;
            S_WAIT:  s_nxt = S_OUT;
            S_OUT:   if (rd.valid_o && rd.ready_i) s_nxt = rd.last_o ? S_IDLE : S_ADDR;
            default: s_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_st       <= S_IDLE;
            rr_ptr     <= '0;
            word       <= '0;
            cur_lab    <= '0;
            rd.addr_o  <= '0;
            rd.dat_o   <= '0;
            rd.valid_o <= 1'b0;
            rd.last_o  <= 1'b0;
            rd.lab_o   <= '0;
        end else begin
            s_st <= s_nxt;
            case (s_st)
                S_IDLE: begin
                    if (grant_any) begin
                        cur_lab   <= grant_idx;
                        word      <= '0;
                        rd.addr_o <= {grant_idx, 11'd0};
                        rr_ptr    <= grant_idx + 2'd1;
                    end
                end
                S_WAIT: begin
                    rd.dat_o   <= rd.dat_i;
                    rd.valid_o <= 1'b1;
                    rd.lab_o   <= cur_lab;
                    rd.last_o  <= (word == 11'(NWORDS - 1));
                end
                S_OUT: begin
                    if (rd.valid_o && rd.ready_i) begin
                        rd.valid_o <= 1'b0;
                        if (!rd.last_o) begin
                            word      <= word + 11'd1;
                            rd.addr_o <= {cur_lab, word + 11'd1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LAB_SCHED_DROP_CNT_EN
    logic [2:0] drop_n;

    always_comb begin
        drop_n = '0;
        for (int n = 0; n < 4; n++)
            if (trig_i[n] && lab_st[n] != L_IDLE)
                drop_n = drop_n + 3'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            drop_cnt_o <= '0;
        else if (drop_clr_i)
            drop_cnt_o <= '0;
        else if (drop_cnt_o > 16'hFFFF - {13'd0, drop_n})
            drop_cnt_o <= 16'hFFFF;
        else
            drop_cnt_o <= drop_cnt_o + {13'd0, drop_n};
    end
`endif

endmodule

// File: tb/tb_lab_readout_sched.sv
// Directed/randomised bench for lab_readout_sched: RAM and LAB models, queue scoreboard of expected words.
module tb_lab_readout_sched;
    localparam int NW   = 1536;
    localparam int HDLY = 4;
    localparam int TMO  = 300;

    typedef struct packed {
        logic [1:0]  lab;
        logic [10:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  trig;
    logic [3:0]  hold_o, digitize_o, busy_o, err_o;
    logic [3:0]  lab_done;
`ifdef LAB_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        drop_clr;
`endif

    lab_readout_sched_if rd();

    lab_readout_sched #(.NWORDS(NW), .HOLD_DLY(HDLY), .DIG_TIMEOUT(TMO)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .trig_i     (trig),
        .hold_o     (hold_o),
        .digitize_o (digitize_o),
        .lab_done_i (lab_done),
        .busy_o     (busy_o),
        .err_o      (err_o),
`ifdef LAB_SCHED_DROP_CNT_EN
        .drop_cnt_o (drop_cnt),
        .drop_clr_i (drop_clr),
`endif
        .rd         (rd)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mem [8192];
    exp_t        exp_q [$];
    int          model_rr = 0;
    bit          rnd_ready = 1'b0;
    bit          stuck [4];
    int          hs_cnt [4], first_hs [4], last_cyc [4], dig_cyc [4], err_cyc [4], hold_rise [4];
    int          lo_at [4], hi_at [4];
    logic [3:0]  prev_hold, prev_dig;
    logic        prev_valid, prev_ready;
    logic [34:0] prev_out;
    logic [12:0] prev_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_tracking();
        prev_hold  = '0;
        prev_dig   = '0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_out   = '0;
        prev_addr  = '0;
        rd.dat_i   = '0;
        lab_done   = 4'hF;
        for (int n = 0; n < 4; n++) begin
            lo_at[n] = -1;
            hi_at[n] = -1;
            stuck[n] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int n = 0; n < 4; n++) begin
            hs_cnt[n]    = 0;
            first_hs[n]  = -1;
            last_cyc[n]  = -1;
            dig_cyc[n]   = -1;
            err_cyc[n]   = -1;
            hold_rise[n] = -1;
        end
    endtask

    // Expected service order: triggered LABs in round-robin order from the modelled pointer.
    task automatic push_order(input logic [3:0] mask);
        int l;
        int last_l;
        last_l = model_rr;
        for (int i = 0; i < 4; i++) begin
            l = (model_rr + i) % 4;
            if (mask[l]) begin
                for (int w = 0; w < NW; w++) exp_q.push_back({2'(l), 11'(w)});
                last_l = l;
            end
        end
        model_rr = (last_l + 1) % 4;
    endtask

    task automatic tick();
        exp_t        e;
        int          l;
        logic [47:0] obs, ex;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 95000) begin
            $display("FAIL cycle_limit: cycle=%0d limit=95000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        rd.dat_i  = mem[prev_addr];
        prev_addr = rd.addr_o;
        for (int n = 0; n < 4; n++) begin
            if (!stuck[n]) begin
                if (cyc == lo_at[n]) lab_done[n] = 1'b0;
                if (cyc == hi_at[n]) lab_done[n] = 1'b1;
            end
            if (digitize_o[n]) begin
                chk("dig_width", 64'(prev_dig[n]), 64'(0));
                dig_cyc[n] = cyc;
                lo_at[n]   = cyc + 2;
                hi_at[n]   = cyc + 20;
            end
            if (err_o[n]) err_cyc[n] = cyc;
            if (hold_o[n] && !prev_hold[n]) hold_rise[n] = cyc;
            if (!hold_o[n] && prev_hold[n] && err_cyc[n] != cyc - 1)
                chk("hold_drop_after_last", {hs_cnt[n], last_cyc[n]}, {NW, cyc - 1});
        end
        rd.ready_i = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (prev_valid && !prev_ready)
            chk("out_stable", 64'({rd.valid_o, rd.last_o, rd.lab_o, rd.dat_o}), 64'({1'b1, prev_out}));
        if (rd.valid_o && rd.ready_i) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                obs = {rd.lab_o, rd.last_o, rd.addr_o, rd.dat_o};
                ex  = {e.lab, (e.w == 11'(NW - 1)), e.lab, e.w, mem[{e.lab, e.w}]};
                chk("word", 64'(obs), 64'(ex));
            end
            l = int'(rd.lab_o);
            hs_cnt[l]++;
            if (hs_cnt[l] == 1) first_hs[l] = cyc;
            if (rd.last_o) last_cyc[l] = cyc;
        end
        prev_hold  = hold_o;
        prev_dig   = digitize_o;
        prev_valid = rd.valid_o;
        prev_ready = rd.ready_i;
        prev_out   = {rd.last_o, rd.lab_o, rd.dat_o};
    endtask

    task automatic pulse(input logic [3:0] mask);
        trig = mask;
        tick();
        trig = '0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        repeat (2) tick();
    endtask

    task automatic wait_dig(input int n, input int budget);
        int b;
        b = budget;
        while (dig_cyc[n] < 0 && b > 0) begin
            tick();
            b--;
        end
        chk("dig_seen", 64'(dig_cyc[n] >= 0), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lab"}, 64'({hold_o, digitize_o, busy_o, err_o}), 64'(0));
        chk({tag, "_str"}, 64'({rd.valid_o, rd.last_o, rd.lab_o, rd.addr_o, rd.dat_o}), 64'(0));
`ifdef LAB_SCHED_DROP_CNT_EN
        chk({tag, "_drop"}, 64'(drop_cnt), 64'(0));
`endif
    endtask

    initial begin
        int t0, d, b;
        trig       = '0;
        rd.ready_i = 1'b0;
        rst_n      = 1'b1;
`ifdef LAB_SCHED_DROP_CNT_EN
        drop_clr   = 1'b0;
`endif
        for (int a = 0; a < 8192; a++) mem[a] = $urandom;
        reset_tracking();
        clear_counts();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 check_zero("rst_held");
        rst_n = 1'b1;

        // All four LABs at once, consumer ready 30% of the time
        rnd_ready = 1'b1;
        clear_counts();
        pulse(4'hF);
        chk("hold_all", 64'(hold_o), 64'(4'hF));
        chk("busy_all", 64'(busy_o), 64'(4'hF));
        push_order(4'hF);
        drain(60000);
        for (int n = 0; n < 4; n++) chk("hs_count_all", 64'(hs_cnt[n]), 64'(NW));

        // Single LAB 0 with ready held high: timing, throughput, dropped retrigger
        rnd_ready = 1'b0;
        clear_counts();
        t0 = cyc;
        pulse(4'h1);
        push_order(4'h1);
        wait_dig(0, 50);
        chk("hold_rise", 64'(hold_rise[0]), 64'(t0 + 1));
        chk("dig_time", 64'(dig_cyc[0]), 64'(t0 + 1 + HDLY));
        tick();
        chk("dig_pulse_1cyc", 64'(digitize_o[0]), 64'(0));
        b = 2000;
        while (hs_cnt[0] < 100 && b > 0) begin tick(); b--; end
        pulse(4'h1);
        drain(8000);
        chk("hs_count_lab0", 64'(hs_cnt[0]), 64'(NW));
        chk("stream_after_done", 64'(first_hs[0] > dig_cyc[0] + 20), 64'(1));
        chk("throughput", 64'(last_cyc[0] - first_hs[0]), 64'(3 * (NW - 1)));
        repeat (10) tick();
        chk("retrig_dropped", 64'(busy_o), 64'(0));

        // LAB 2 with done stuck high: timeout, with a trigger in the timeout cycle
        clear_counts();
        stuck[2] = 1'b1;
        pulse(4'h4);
        wait_dig(2, 50);
        d = dig_cyc[2];
        b = TMO + 20;
        while (err_cyc[2] < 0 && b > 0) begin tick(); b--; end
        chk("err_time", 64'(err_cyc[2] - d), 64'(TMO));
        trig = 4'h4;
        tick();
        trig = '0;
        chk("err_1cyc", 64'(err_o[2]), 64'(0));
        chk("to_hold_drop", 64'({hold_o[2], busy_o[2]}), 64'(0));
        tick();
        chk("to_trig_dropped", 64'(hold_o[2]), 64'(0));
        stuck[2] = 1'b0;

        // Reset in the middle of LAB 1, then restart from word 0
        clear_counts();
        pulse(4'h2);
        push_order(4'h2);
        b = 20000;
        while (hs_cnt[1] < 700 && b > 0) begin tick(); b--; end
        chk("reached_700", 64'(hs_cnt[1]), 64'(700));
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        reset_tracking();
        model_rr = 0;
        clear_counts();
        pulse(4'h2);
        push_order(4'h2);
        drain(8000);
        chk("hs_count_restart", 64'(hs_cnt[1]), 64'(NW));

`ifdef LAB_SCHED_DROP_CNT_EN
        // Dropped-trigger counter on LAB 3
        clear_counts();
        pulse(4'h8);
        push_order(4'h8);
        wait_dig(3, 50);
        repeat (5) begin
            pulse(4'h8);
        end
        tick();
        chk("drop_cnt5", 64'(drop_cnt), 64'(5));
        drop_clr = 1'b1;
        trig     = 4'h8;
        tick();
        drop_clr = 1'b0;
        trig     = '0;
        chk("drop_clr_wins", 64'(drop_cnt), 64'(0));
        drain(8000);
        chk("hs_count_lab3", 64'(hs_cnt[3]), 64'(NW));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
